// File: rtl/dsp_mac_pipe_if.sv
// Handshake and data bundle for the pipelined multiply-accumulate unit.
// The master side feeds operands and accepts results; the slave side is the MAC.
`timescale 1ns/1ps

interface dsp_mac_pipe_if #(
   parameter int N     = 16,
   parameter int M     = 16,
   parameter int ACC_W = 40
);
   logic             in_valid;
   logic             in_ready;
   logic [N-1:0]     a;
   logic [M-1:0]     b;
   logic             acc_en;
   logic             acc_clr;
   logic             out_valid;
   logic             out_ready;
   logic [ACC_W-1:0] out_acc;
   logic             out_ovf;

   modport master (
      output in_valid, a, b, acc_en, acc_clr, out_ready,
      input  in_ready, out_valid, out_acc, out_ovf
   );

   modport slave (
      input  in_valid, a, b, acc_en, acc_clr, out_ready,
      output in_ready, out_valid, out_acc, out_ovf
   );
endinterface

// File: rtl/dsp_mac_pipe.sv
// Pipelined multiply-accumulate unit. Operands are registered, reduced to a
// carry-save pair, carried through PIPE stages, then resolved and optionally
// accumulated in the final stage. A single advance enable stalls every stage
// when the output is held by downstream backpressure.
`timescale 1ns/1ps

module dsp_mac_pipe #(
   parameter int N      = 16,
   parameter int M      = 16,
   parameter int ACC_W  = 40,
   parameter int SIGNED = 1,
   parameter int PIPE   = 2
) (
   input logic            clk,
   input logic            rst_n,
   dsp_mac_pipe_if.slave  bus
);

   localparam int W = N + M;

   if (ACC_W < N + M) begin : g_acc_w_check
      $error("dsp_mac_pipe: ACC_W must be at least N+M");
   end
   if (PIPE < 1 || PIPE > 3) begin : g_pipe_check
      $error("dsp_mac_pipe: PIPE must be in the range 1..3");
   end

   logic             adv;

   logic [PIPE:0]    st_valid;
   logic [PIPE:0]    st_en;
   logic [PIPE:0]    st_clr;
   logic [N-1:0]     s0_a;
   logic [M-1:0]     s0_b;
   logic [W-1:0]     cs_sum   [1:PIPE];
   logic [W-1:0]     cs_carry [1:PIPE];

   logic [W-1:0]     a_ext;
   logic [W-1:0]     pp;
   logic [W-1:0]     red_sum;
   logic [W-1:0]     red_carry;
   logic [W-1:0]     red_tmp;

   logic [W-1:0]     prod_w;
   logic [ACC_W-1:0] prod_ext;
   logic [ACC_W:0]   sum_full;
   logic             ovf_now;

   logic [ACC_W-1:0] acc_q;
   logic [ACC_W-1:0] out_acc_q;
   logic             out_valid_q;
   logic             out_ovf_q;

   // The whole pipe moves only when the output register is empty or being taken.
   assign adv           = !out_valid_q || bus.out_ready;
   assign bus.in_ready  = adv;
   assign bus.out_valid = out_valid_q;
   assign bus.out_acc   = out_acc_q;
   assign bus.out_ovf   = out_ovf_q;

   // Partial products compressed row by row into a carry-save pair; in signed
   // mode the top row carries negative weight and is negated as ~row + 1, with
   // the +1 seeded into the carry vector.
   always_comb begin
      a_ext     = '0;
      pp        = '0;
      red_tmp   = '0;
      red_sum   = '0;
      red_carry = (SIGNED != 0) ? W'(1) : '0;
      if (SIGNED != 0) a_ext = W'($signed(s0_a));
      else             a_ext = W'(s0_a);
      for (int j = 0; j < M; j++) begin
         pp = s0_b[j] ? (a_ext << j) : '0;
         if ((SIGNED != 0) && (j == M - 1)) pp = ~pp;
         red_tmp   = ((red_sum & red_carry) | (red_sum & pp) | (red_carry & pp)) << 1;
         red_sum   = red_sum ^ red_carry ^ pp;
         red_carry = red_tmp;
      end
   end

   // Resolve the carry-save pair, extend it and form the accumulation sum and its overflow.
   always_comb begin
      prod_w   = cs_sum[PIPE] + cs_carry[PIPE];
      prod_ext = '0;
      if (SIGNED != 0) prod_ext = ACC_W'($signed(prod_w));
      else             prod_ext = ACC_W'(prod_w);
      sum_full = {1'b0, acc_q} + {1'b0, prod_ext};
      if (SIGNED != 0)
         ovf_now = (acc_q[ACC_W-1] == prod_ext[ACC_W-1]) &&
                   (sum_full[ACC_W-1] != acc_q[ACC_W-1]);
      else
         ovf_now = sum_full[ACC_W];
   end

   // Operand capture and carry-save stages, all frozen while the output is stalled.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st_valid <= '0;
         st_en    <= '0;
         st_clr   <= '0;
         s0_a     <= '0;
         s0_b     <= '0;
         for (int k = 1; k <= PIPE; k++) begin
            cs_sum[k]   <= '0;
            cs_carry[k] <= '0;
         end
      end else if (adv) begin
         st_valid[0] <= bus.in_valid;
         st_en[0]    <= bus.acc_en;
         st_clr[0]   <= bus.acc_clr;
         s0_a        <= bus.a;
         s0_b        <= bus.b;
         for (int k = 1; k <= PIPE; k++) begin
            st_valid[k] <= st_valid[k-1];
            st_en[k]    <= st_en[k-1];
            st_clr[k]   <= st_clr[k-1];
         end
         cs_sum[1]   <= red_sum;
         cs_carry[1] <= red_carry;
         for (int k = 2; k <= PIPE; k++) begin
            cs_sum[k]   <= cs_sum[k-1];
            cs_carry[k] <= cs_carry[k-1];
         end
      end
   end

   // Final stage: pass-through, restart or accumulate, with a sticky overflow flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q <= 1'b0;
         out_acc_q   <= '0;
         out_ovf_q   <= 1'b0;
         acc_q       <= '0;
      end else if (adv) begin
         out_valid_q <= st_valid[PIPE];
         if (st_valid[PIPE]) begin
            if (!st_en[PIPE]) begin
               out_acc_q <= prod_ext;
            end else if (st_clr[PIPE]) begin
               acc_q     <= prod_ext;
               out_acc_q <= prod_ext;
               out_ovf_q <= 1'b0;
            end else begin
               acc_q     <= sum_full[ACC_W-1:0];
               out_acc_q <= sum_full[ACC_W-1:0];
               out_ovf_q <= out_ovf_q | ovf_now;
            end
         end
      end
   end

endmodule
